seq_trace_recorder: RTL and testbench
=====================================

Name: seq_trace_recorder

Overview:
- Hardware-side counterpart to the sequence stimulus driver.
- The driver replays stored {rst, in} words into the checked FSM. This block captures {rst, in, out} per clock into a circular trace buffer around a trigger (e.g. assertion failure).
- It then streams the captured window out oldest-first, so it can be dumped in the same one-word-per-cycle format as the input_sequence file.
- Sits beside the FSM under check, observing its ports.

Parameters:
- IN_LEN, 8, width of observed FSM input vector
- OUT_LEN, 19, width of observed FSM output vector
- DEPTH, 1024, trace entries; power of two, >= 4
- ADDR_W, $clog2(DEPTH), pointer width (derived)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse: start capturing
- trig  in  1  trigger event, level, sampled each clock
- post_cnt  in  ADDR_W  samples to record after the trigger sample; sampled on the trigger cycle
- smp_rst  in  1  observed FSM reset bit
- smp_in  in  IN_LEN  observed FSM input
- smp_out  in  OUT_LEN  observed FSM output
- rd_ready  in  1  consumer ready
- rd_valid  out  1  readout word valid
- rd_data  out  1+IN_LEN+OUT_LEN  {smp_rst, smp_in, smp_out}, MSB first
- rd_last  out  1  marks final readout word
- busy  out  1  high in any state other than IDLE
- trig_pos  out  ADDR_W+1  0-based readout index of the trigger sample; valid in READ

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; all pointers/counters=0.
  - rd_valid=0, rd_last=0, busy=0, trig_pos=0.
  - RAM contents are not cleared.
- States: IDLE, PRE, POST, READ.
- IDLE:
  - No writes.
  - arm=1 -> PRE; wr_ptr=0, fill=0.
- PRE:
  - Every clock writes the sample to RAM[wr_ptr].
  - wr_ptr increments modulo DEPTH; fill saturates at DEPTH.
  - trig=1 on a cycle: that cycle's sample is written (it is the trigger sample), post_cnt is latched into rem.
    - If post_cnt==0 -> READ.
    - Otherwise -> POST.
- POST:
  - Writes each clock; rem decrements.
  - The write with rem==1 is the last one -> READ.
  - Exactly post_cnt samples follow the trigger sample.
- Ignored inputs:
  - arm is ignored outside IDLE.
  - trig is ignored outside PRE.
  - post_cnt >= DEPTH is impossible by width; post_cnt==DEPTH-1 is legal and overwrites all pre-trigger history except the trigger sample.
- READ entry:
  - rd_ptr = (wr_ptr - fill) mod DEPTH, using fill after the final write.
  - trig_pos = fill - post_cnt_latched - 1.
  - N = fill words are delivered.
- READ readout timing:
  - RAM read is synchronous.
  - rd_valid first rises on the 2nd clock edge after the edge that wrote the final sample.
- READ handshake:
  - Transfer occurs on a clock edge with rd_valid & rd_ready.
  - rd_data and rd_last are held stable while rd_valid & !rd_ready.
  - With rd_ready held high, one word transfers every clock, with no bubbles. This requires a prefetch/skid register.
  - rd_last=1 exactly with word N-1.
  - Transfer of the last word -> IDLE, rd_valid=0 on the next cycle.
- Wrap-around:
  - Ordering is oldest-first regardless of how many times wr_ptr wrapped.
  - fill never exceeds DEPTH.
- Reset mid-operation (any state): immediate return to IDLE; an in-flight readout is abandoned and rd_valid drops asynchronously.
- arm and trig on the same IDLE cycle: arm is taken; that trig is ignored. Capture starts the next cycle.

Decomposition:
- Package seq_trace_pkg:
  - state enum (IDLE, PRE, POST, READ)
  - TRACE_W = 1+IN_LEN+OUT_LEN, as a localparam function of the parameters
- Sub-module trace_ram:
  - simple dual-port, 1 write / 1 read, synchronous read, DEPTH x TRACE_W, no reset
  - instantiated once

Test Plan (DEPTH=16, IN_LEN=8, OUT_LEN=19; sample k carries smp_in=k[7:0], smp_out=k, smp_rst=0):
- No wrap: arm at cycle 0, trig on sample 5, post_cnt=3 -> 9 words k=0..8 in order, trig_pos=5, rd_last on k=8, rd_ready=1 gives 9 consecutive valid cycles.
- Wrap: trig on sample 40, post_cnt=4 -> 16 words k=29..44, trig_pos=11.
- post_cnt=0: trig on sample 20 -> 16 words k=5..20, trig_pos=15, READ entered directly from PRE.
- Backpressure: scenario 1 with rd_ready toggling 1,0,0,1,... -> rd_data held constant during stalls, same 9-word sequence, no duplicates or drops.
- Ignored inputs: arm pulses in PRE/POST/READ and trig pulses in POST/READ -> no effect on the captured window, trig_pos, or word count.
- Async reset (rst=0 mid-POST and mid-READ) -> rd_valid=0 and busy=0 immediately. A subsequent arm and capture behaves like a fresh scenario 1.

Source files
------------

// File: rtl/seq_trace_pkg.sv
// Shared types and width helpers for the sequence trace recorder.
package seq_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    READ = 2'd3
  } state_t;

  localparam int IN_LEN_DEF  = 8;
  localparam int OUT_LEN_DEF = 19;

  // One trace word is {rst, in, out}.
  function automatic int trace_w(input int in_len, input int out_len);
    return 1 + in_len + out_len;
  endfunction

  localparam int TRACE_W = trace_w(IN_LEN_DEF, OUT_LEN_DEF);

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one synchronous read port.
module trace_ram #(
  parameter int DEPTH  = 1024,
  parameter int W      = 28,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/seq_trace_recorder.sv
// Captures {rst, in, out} of an observed FSM around a trigger and streams the
// captured window out oldest-first over a valid/ready interface.
module seq_trace_recorder
  import seq_trace_pkg::*;
#(
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 19,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic                            trig,
  input  logic [ADDR_W-1:0]               post_cnt,
  input  logic                            smp_rst,
  input  logic [IN_LEN-1:0]               smp_in,
  input  logic [OUT_LEN-1:0]              smp_out,
  input  logic                            rd_ready,
  output logic                            rd_valid,
  output logic [trace_w(IN_LEN, OUT_LEN)-1:0] rd_data,
  output logic                            rd_last,
  output logic                            busy,
  output logic [ADDR_W:0]                 trig_pos
);

  localparam int TW = trace_w(IN_LEN, OUT_LEN);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t state, state_nx;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rem, post_lat, post_sel, wr_ptr_nx;
  logic [ADDR_W:0]   fill, fill_nx, rd_left;
  logic              we, enter_read, issue, pop;
  logic [TW-1:0]     ram_q;

  // Readout pipeline: one RAM read in flight, an output register and a skid register.
  logic          pend, pend_last;
  logic          out_v, out_last, sk_v, sk_last;
  logic [TW-1:0] out_d, sk_d;
  logic [1:0]    occ;

  assign wr_ptr_nx = wr_ptr + 1'b1;
  assign fill_nx   = (fill == FULL) ? fill : fill + 1'b1;
  assign post_sel  = (state == PRE) ? post_cnt : post_lat;

  assign pop   = out_v & rd_ready;
  assign occ   = 2'(out_v) + 2'(sk_v) + 2'(pend);
  assign issue = (state == READ) && (rd_left != '0) && ((occ - 2'(pop)) < 2'd2);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx   = state;
    we         = 1'b0;
    enter_read = 1'b0;
    unique case (state)
      IDLE: if (arm) state_nx = PRE;
      PRE: begin
        we = 1'b1;
        if (trig) begin
          if (post_cnt == '0) begin
            state_nx   = READ;
            enter_read = 1'b1;
          end else begin
            state_nx = POST;
          end
        end
      end
      POST: begin
        we = 1'b1;
        if (rem == ADDR_W'(1)) begin
          state_nx   = READ;
          enter_read = 1'b1;
        end
      end
      READ: if (pop && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      rem      <= '0;
      post_lat <= '0;
      rd_ptr   <= '0;
      rd_left  <= '0;
      trig_pos <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && arm) begin
        wr_ptr <= '0;
        fill   <= '0;
      end
      if (we) begin
        wr_ptr <= wr_ptr_nx;
        fill   <= fill_nx;
      end
      if (state == PRE && trig) begin
        rem      <= post_cnt;
        post_lat <= post_cnt;
      end
      if (state == POST) rem <= rem - 1'b1;
      // Oldest entry sits fill slots behind the write pointer after the final write.
      if (enter_read) begin
        rd_ptr   <= wr_ptr_nx - fill_nx[ADDR_W-1:0];
        rd_left  <= fill_nx;
        trig_pos <= fill_nx - {1'b0, post_sel} - 1'b1;
      end else if (issue) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      pend_last <= 1'b0;
      out_v     <= 1'b0;
      out_last  <= 1'b0;
      out_d     <= '0;
      sk_v      <= 1'b0;
      sk_last   <= 1'b0;
      sk_d      <= '0;
    end else begin
      pend      <= issue;
      pend_last <= (rd_left == (ADDR_W+1)'(1));
      // The skid entry is always older than a word arriving from the RAM.
      if (!out_v || pop) begin
        if (sk_v) begin
          out_v    <= 1'b1;
          out_d    <= sk_d;
          out_last <= sk_last;
          sk_v     <= pend;
          sk_d     <= ram_q;
          sk_last  <= pend_last;
        end else if (pend) begin
          out_v    <= 1'b1;
          out_d    <= ram_q;
          out_last <= pend_last;
        end else begin
          out_v    <= 1'b0;
          out_last <= 1'b0;
        end
      end else if (pend) begin
        sk_v    <= 1'b1;
        sk_d    <= ram_q;
        sk_last <= pend_last;
      end
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .W      (TW),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({smp_rst, smp_in, smp_out}),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign rd_valid = out_v;
  assign rd_data  = out_d;
  assign rd_last  = out_last;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_seq_trace_recorder.sv
// Directed bench for seq_trace_recorder with DEPTH=16; sample k carries in=k, out=k.
module tb_seq_trace_recorder;

  localparam int IN_LEN  = 8;
  localparam int OUT_LEN = 19;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TW      = 1 + IN_LEN + OUT_LEN;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arm = 1'b0;
  logic              trig = 1'b0;
  logic [ADDR_W-1:0] post_cnt = '0;
  logic              smp_rst = 1'b0;
  logic [IN_LEN-1:0] smp_in = '0;
  logic [OUT_LEN-1:0] smp_out = '0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [TW-1:0]     rd_data;
  logic              rd_last;
  logic              busy;
  logic [ADDR_W:0]   trig_pos;

  int n_checks = 0;
  int n_errors = 0;

  seq_trace_recorder #(
    .IN_LEN  (IN_LEN),
    .OUT_LEN (OUT_LEN),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .trig     (trig),
    .post_cnt (post_cnt),
    .smp_rst  (smp_rst),
    .smp_in   (smp_in),
    .smp_out  (smp_out),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .busy     (busy),
    .trig_pos (trig_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int k);
    smp_rst = 1'b0;
    smp_in  = 8'(k);
    smp_out = 19'(k);
  endtask

  function automatic logic [TW-1:0] word_of(input int k);
    return {1'b0, 8'(k), 19'(k)};
  endfunction

  // Arms, feeds samples 0..trig_k+post and leaves the bench just after the final write edge.
  task automatic run_capture(input int trig_k, input int post, input bit noise);
    arm = 1'b1;
    if (noise) begin
      trig     = 1'b1;
      post_cnt = '0;
    end
    tick();
    arm  = 1'b0;
    trig = 1'b0;
    check("arm_busy", 64'(busy), 64'd1);
    set_sample(0);
    for (int i = 0; i < trig_k; i++) begin
      if (noise && i == 1) arm = 1'b1;
      tick();
      arm = 1'b0;
      set_sample(i + 1);
    end
    trig     = 1'b1;
    post_cnt = ADDR_W'(post);
    tick();
    trig     = 1'b0;
    post_cnt = noise ? ADDR_W'(15) : '0;
    for (int i = 0; i < post; i++) begin
      set_sample(trig_k + 1 + i);
      if (noise && i == 0) begin
        arm  = 1'b1;
        trig = 1'b1;
      end
      tick();
      arm  = 1'b0;
      trig = 1'b0;
    end
  endtask

  task automatic readout(input int first_k, input int n, input int tpos, input bit bp, input bit noise);
    int            got = 0;
    int            first = -1;
    int            bubbles = 0;
    bit            done = 1'b0;
    bit            prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    for (int idx = 0; idx < 100 && !done; idx++) begin
      if (idx == 0) begin
        check("read_entry_busy", 64'(busy), 64'd1);
        check("read_entry_valid", 64'(rd_valid), 64'd0);
      end
      if (rd_valid && first < 0) begin
        first = idx;
        check("first_valid_latency", 64'(idx), 64'd2);
        check("trig_pos", 64'(trig_pos), 64'(tpos));
      end
      if (prev_stall) begin
        check("stall_valid", 64'(rd_valid), 64'd1);
        check("stall_data", 64'(rd_data), 64'(prev_data));
        check("stall_last", 64'(rd_last), 64'(prev_last));
      end
      rd_ready = bp ? (idx % 3 == 0) : 1'b1;
      if (noise && idx == 3) begin
        arm  = 1'b1;
        trig = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        check("word_data", 64'(rd_data), 64'(word_of(first_k + got)));
        check("word_last", 64'(rd_last), 64'(got == n - 1));
        got++;
        if (got == n || rd_last) done = 1'b1;
      end else if (first >= 0 && !rd_valid) begin
        bubbles++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
      tick();
      arm  = 1'b0;
      trig = 1'b0;
    end
    rd_ready = 1'b0;
    if (!done) check("read_timeout", 64'd0, 64'd1);
    check("word_count", 64'(got), 64'(n));
    check("no_bubbles", 64'(bubbles), 64'd0);
    check("end_valid", 64'(rd_valid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    set_sample(0);
    #3;
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_last", 64'(rd_last), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_trig_pos", 64'(trig_pos), 64'd0);
    tick();
    release_reset();
    check("idle_busy", 64'(busy), 64'd0);

    // No wrap: window 0..8, trigger at index 5.
    run_capture(5, 3, 1'b0);
    readout(0, 9, 5, 1'b0, 1'b0);

    // Wrapped buffer: window 29..44, trigger at index 11.
    run_capture(40, 4, 1'b0);
    readout(29, 16, 11, 1'b0, 1'b0);

    // Zero post-trigger samples: READ straight from PRE.
    run_capture(20, 0, 1'b0);
    readout(5, 16, 15, 1'b0, 1'b0);

    // Backpressure on the no-wrap capture.
    run_capture(5, 3, 1'b0);
    readout(0, 9, 5, 1'b1, 1'b0);

    // Stray arm/trig pulses must not disturb the capture.
    run_capture(5, 3, 1'b1);
    readout(0, 9, 5, 1'b0, 1'b1);

    // Reset while in POST.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    set_sample(0);
    for (int i = 0; i < 2; i++) begin
      tick();
      set_sample(i + 1);
    end
    trig     = 1'b1;
    post_cnt = ADDR_W'(5);
    tick();
    trig = 1'b0;
    set_sample(3);
    tick();
    check("mid_post_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("post_rst_valid", 64'(rd_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    release_reset();

    // Reset while a word is being presented in READ.
    run_capture(5, 3, 1'b0);
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mid_read_valid", 64'(rd_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("read_rst_valid", 64'(rd_valid), 64'd0);
    check("read_rst_busy", 64'(busy), 64'd0);
    release_reset();

    // Fresh capture after the aborted ones.
    run_capture(5, 3, 1'b0);
    readout(0, 9, 5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
